controlador_banco: RTL and testbench

Multi-cycle sequencer that is the initiator side of the 16x16 register bank. It accepts one instruction at a time over a valid/ready handshake and drives the bank's two read addresses. It computes the result in a small ALU, then writes the result back through the bank's write port (`enable`, `endereco_escrita`, `conteudo_escrita`). It also issues bank clears. It sits between the instruction source (switches/FSM upstream) and the register bank.

---
 rtl/controlador_pkg.sv | 31 +++
 rtl/ula_controlador.sv | 60 ++++++
 rtl/controlador_banco.sv | 135 +++++++++++++
 tb/tb_controlador_banco.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_pkg.sv
// Shared constants for the register-bank sequencer: bank geometry, opcodes and FSM encoding.
package controlador_pkg;

    localparam int LARGURA_DADO = 16;
    localparam int LARGURA_END  = 4;
    localparam int LARGURA_IMM  = 7;
    localparam int LARGURA_OP   = 3;

    localparam logic [LARGURA_OP-1:0] OP_ADD    = 3'b000;
    localparam logic [LARGURA_OP-1:0] OP_ADDI   = 3'b001;
    localparam logic [LARGURA_OP-1:0] OP_SUB    = 3'b010;
    localparam logic [LARGURA_OP-1:0] OP_SUBI   = 3'b011;
    localparam logic [LARGURA_OP-1:0] OP_MUL    = 3'b100;
    localparam logic [LARGURA_OP-1:0] OP_CLEAR  = 3'b101;
    localparam logic [LARGURA_OP-1:0] OP_LOAD   = 3'b110;
    localparam logic [LARGURA_OP-1:0] OP_ILEGAL = 3'b111;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        LEITURA = 3'd1,
        EXECUTA = 3'd2,
        ESCRITA = 3'd3,
        LIMPEZA = 3'd4
    } estado_t;

    // Second ALU operand comes from the immediate field instead of the bank.
    function automatic logic usa_imediato(input logic [LARGURA_OP-1:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/ula_controlador.sv
// Combinational ALU of the bank sequencer plus the legality decode of incoming opcodes.
// CONTROLADOR_MUL_EN enables opcode 100 (MUL); without it that opcode is illegal.
module ula_controlador
    import controlador_pkg::*;
(
    input  logic [LARGURA_OP-1:0]   opcode,
    input  logic [LARGURA_DADO-1:0] a,
    input  logic [LARGURA_DADO-1:0] b,
    input  logic [LARGURA_OP-1:0]   opcode_teste,
    output logic [LARGURA_DADO-1:0] resultado,
    output logic                    estouro,
    output logic                    ilegal
);

    logic [LARGURA_DADO:0] soma;
    logic [LARGURA_DADO:0] diferenca;

    assign soma      = {1'b0, a} + {1'b0, b};
    // Zero-extended subtraction: bit 16 is the unsigned borrow (a < b).
    assign diferenca = {1'b0, a} - {1'b0, b};

`ifdef CONTROLADOR_MUL_EN
    logic [2*LARGURA_DADO-1:0] produto;

    assign produto = {{LARGURA_DADO{1'b0}}, a} * {{LARGURA_DADO{1'b0}}, b};
    assign ilegal  = (opcode_teste == OP_ILEGAL);
`else
    assign ilegal  = (opcode_teste == OP_ILEGAL) || (opcode_teste == OP_MUL);
`endif

    always_comb begin
        resultado = '0;
        estouro   = 1'b0;
        case (opcode)
            OP_ADD, OP_ADDI: begin
                resultado = soma[LARGURA_DADO-1:0];
                estouro   = soma[LARGURA_DADO];
            end
            OP_SUB, OP_SUBI: begin
                resultado = diferenca[LARGURA_DADO-1:0];
                estouro   = diferenca[LARGURA_DADO];
            end
`ifdef CONTROLADOR_MUL_EN
            OP_MUL: begin
                resultado = produto[LARGURA_DADO-1:0];
                estouro   = |produto[2*LARGURA_DADO-1:LARGURA_DADO];
            end
`endif
            OP_LOAD: begin
                resultado = b;
                estouro   = 1'b0;
            end
            default: begin
                resultado = '0;
                estouro   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/controlador_banco.sv
// Initiator of the 16x16 register bank: accepts one instruction, reads operands,
// runs the ALU and writes the result back, or issues a bank clear.
//
// state   | meaning
// OCIOSO  | pronto=1, waiting for a handshake; illegal opcodes pulse erro here
// LEITURA | bank read addresses hold latched src1/src2, operands captured at cycle end
// EXECUTA | ALU result/flag registered into resultado/estouro
// ESCRITA | enable=1 with latched dest, concluido=1
// LIMPEZA | ativar_clear=1 for one cycle, concluido=1
module controlador_banco
    import controlador_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valida,
    input  logic [LARGURA_OP-1:0]   opcode,
    input  logic [LARGURA_END-1:0]  dest,
    input  logic [LARGURA_END-1:0]  src1,
    input  logic [LARGURA_END-1:0]  src2,
    input  logic [LARGURA_IMM-1:0]  imediato,
    output logic                    pronto,
    output logic [LARGURA_END-1:0]  endereco_reg1,
    output logic [LARGURA_END-1:0]  endereco_reg2,
    input  logic [LARGURA_DADO-1:0] conteudo_reg1,
    input  logic [LARGURA_DADO-1:0] conteudo_reg2,
    output logic                    enable,
    output logic [LARGURA_END-1:0]  endereco_escrita,
    output logic [LARGURA_DADO-1:0] conteudo_escrita,
    output logic                    ativar_clear,
    output logic                    concluido,
    output logic [LARGURA_DADO-1:0] resultado,
    output logic                    estouro,
    output logic                    erro
);

    estado_t                 estado;
    logic [LARGURA_OP-1:0]   op_r;
    logic [LARGURA_END-1:0]  dest_r;
    logic [LARGURA_IMM-1:0]  imm_r;
    logic [LARGURA_DADO-1:0] opnd_a;
    logic [LARGURA_DADO-1:0] opnd_b;

    logic [LARGURA_DADO-1:0] ula_resultado;
    logic                    ula_estouro;
    logic                    opcode_ilegal;

    ula_controlador u_ula (
        .opcode       (op_r),
        .a            (opnd_a),
        .b            (opnd_b),
        .opcode_teste (opcode),
        .resultado    (ula_resultado),
        .estouro      (ula_estouro),
        .ilegal       (opcode_ilegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado           <= OCIOSO;
            pronto           <= 1'b1;
            enable           <= 1'b0;
            concluido        <= 1'b0;
            erro             <= 1'b0;
            // Held high through reset so the bank comes up cleared.
            ativar_clear     <= 1'b1;
            resultado        <= '0;
            estouro          <= 1'b0;
            endereco_reg1    <= '0;
            endereco_reg2    <= '0;
            endereco_escrita <= '0;
            conteudo_escrita <= '0;
            op_r             <= '0;
            dest_r           <= '0;
            imm_r            <= '0;
            opnd_a           <= '0;
            opnd_b           <= '0;
        end else begin
            enable       <= 1'b0;
            concluido    <= 1'b0;
            erro         <= 1'b0;
            ativar_clear <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (instr_valida && pronto) begin
                        op_r          <= opcode;
                        dest_r        <= dest;
                        imm_r         <= imediato;
                        endereco_reg1 <= src1;
                        endereco_reg2 <= src2;
                        if (opcode == OP_CLEAR) begin
                            estado       <= LIMPEZA;
                            pronto       <= 1'b0;
                            ativar_clear <= 1'b1;
                            concluido    <= 1'b1;
                        end else if (opcode_ilegal) begin
                            erro <= 1'b1;
                        end else begin
                            estado <= LEITURA;
                            pronto <= 1'b0;
                        end
                    end
                end
                LEITURA: begin
                    opnd_a <= conteudo_reg1;
                    opnd_b <= usa_imediato(op_r)
                              ? {{(LARGURA_DADO-LARGURA_IMM){1'b0}}, imm_r}
                              : conteudo_reg2;
                    estado <= EXECUTA;
                end
                EXECUTA: begin
                    resultado        <= ula_resultado;
                    estouro          <= ula_estouro;
                    enable           <= 1'b1;
                    concluido        <= 1'b1;
                    endereco_escrita <= dest_r;
                    conteudo_escrita <= ula_resultado;
                    estado           <= ESCRITA;
                end
                ESCRITA: begin
                    estado <= OCIOSO;
                    pronto <= 1'b1;
                end
                LIMPEZA: begin
                    estado <= OCIOSO;
                    pronto <= 1'b1;
                end
                default: begin
                    estado <= OCIOSO;
                    pronto <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_banco.sv
// Directed bench for controlador_banco with a behavioural 16x16 register bank attached.
// Expects MUL behaviour when CONTROLADOR_MUL_EN is defined, illegal-opcode behaviour otherwise.
module tb_controlador_banco;

    logic        clk;
    logic        rst_n;
    logic        instr_valida;
    logic [2:0]  opcode;
    logic [3:0]  dest, src1, src2;
    logic [6:0]  imediato;
    logic        pronto;
    logic [3:0]  endereco_reg1, endereco_reg2;
    logic [15:0] conteudo_reg1, conteudo_reg2;
    logic        enable;
    logic [3:0]  endereco_escrita;
    logic [15:0] conteudo_escrita;
    logic        ativar_clear;
    logic        concluido;
    logic [15:0] resultado;
    logic        estouro;
    logic        erro;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [16];
    int          wr_count = 0;
    int          clr_count = 0;
    int          hs_count = 0;
    logic [3:0]  last_wr_addr = '0;
    logic [15:0] last_wr_data = '0;

    controlador_banco dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instr_valida     (instr_valida),
        .opcode           (opcode),
        .dest             (dest),
        .src1             (src1),
        .src2             (src2),
        .imediato         (imediato),
        .pronto           (pronto),
        .endereco_reg1    (endereco_reg1),
        .endereco_reg2    (endereco_reg2),
        .conteudo_reg1    (conteudo_reg1),
        .conteudo_reg2    (conteudo_reg2),
        .enable           (enable),
        .endereco_escrita (endereco_escrita),
        .conteudo_escrita (conteudo_escrita),
        .ativar_clear     (ativar_clear),
        .concluido        (concluido),
        .resultado        (resultado),
        .estouro          (estouro),
        .erro             (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ativar_clear === 1'b1) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            clr_count <= clr_count + 1;
        end else if (enable === 1'b1) begin
            mem[endereco_escrita] <= conteudo_escrita;
            wr_count     <= wr_count + 1;
            last_wr_addr <= endereco_escrita;
            last_wr_data <= conteudo_escrita;
        end
        if (rst_n && instr_valida && pronto) hs_count <= hs_count + 1;
    end

    assign conteudo_reg1 = mem[endereco_reg1];
    assign conteudo_reg2 = mem[endereco_reg2];

    // Drives one instruction. Returns at the negedge after the handshake edge when
    // wait_done=0, otherwise at the first negedge after the concluido cycle.
    task automatic run_op(input logic [2:0] op, input logic [3:0] d, input logic [3:0] s1,
                          input logic [3:0] s2, input logic [6:0] imm, input bit wait_done);
        int n;
        @(negedge clk);
        opcode = op; dest = d; src1 = s1; src2 = s2; imediato = imm;
        instr_valida = 1'b1;
        n = 0;
        while (pronto !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (pronto !== 1'b1) begin
            bad++;
            $display("FAIL handshake_timeout pronto=%b want 1", pronto);
            instr_valida = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        instr_valida = 1'b0;
        if (wait_done) begin
            n = 0;
            while (concluido !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            total++;
            if (concluido !== 1'b1) begin
                bad++;
                $display("FAIL done_timeout concluido=%b want 1", concluido);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valida = 1'b0;
        opcode = '0; dest = '0; src1 = '0; src2 = '0; imediato = '0;
        repeat (3) @(negedge clk);
        total++; if (pronto !== 1'b1) begin bad++; $display("FAIL rst_pronto got=%b want=1", pronto); end
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL rst_enable got=%b want=0", enable); end
        total++; if (concluido !== 1'b0 || erro !== 1'b0) begin bad++; $display("FAIL rst_pulses concluido=%b erro=%b want 0 0", concluido, erro); end
        total++; if (resultado !== 16'h0 || estouro !== 1'b0) begin bad++; $display("FAIL rst_result got=%h/%b want 0000/0", resultado, estouro); end
        total++; if (endereco_escrita !== 4'h0 || conteudo_escrita !== 16'h0 || endereco_reg1 !== 4'h0 || endereco_reg2 !== 4'h0) begin
            bad++; $display("FAIL rst_addr wa=%h wd=%h r1=%h r2=%h want 0", endereco_escrita, conteudo_escrita, endereco_reg1, endereco_reg2); end
        total++; if (ativar_clear !== 1'b1) begin bad++; $display("FAIL rst_clear got=%b want=1", ativar_clear); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (ativar_clear !== 1'b0) begin bad++; $display("FAIL rst_clear_release got=%b want=0", ativar_clear); end
        total++; if (pronto !== 1'b1) begin bad++; $display("FAIL rst_pronto_release got=%b want=1", pronto); end
    endtask

    task automatic test_addi();
        int w0;
        w0 = wr_count;
        run_op(3'b001, 4'd1, 4'd0, 4'd0, 7'd5, 1'b0);
        total++; if (pronto !== 1'b0 || enable !== 1'b0) begin bad++; $display("FAIL addi_leitura pronto=%b enable=%b want 0 0", pronto, enable); end
        @(negedge clk);
        total++; if (enable !== 1'b0) begin bad++; $display("FAIL addi_executa enable=%b want 0", enable); end
        @(negedge clk);
        total++; if (enable !== 1'b1 || concluido !== 1'b1) begin bad++; $display("FAIL addi_escrita enable=%b concluido=%b want 1 1", enable, concluido); end
        total++; if (endereco_escrita !== 4'd1 || conteudo_escrita !== 16'h0005) begin bad++; $display("FAIL addi_wdata addr=%h data=%h want 1 0005", endereco_escrita, conteudo_escrita); end
        total++; if (resultado !== 16'h0005 || estouro !== 1'b0) begin bad++; $display("FAIL addi_result got=%h/%b want 0005/0", resultado, estouro); end
        @(negedge clk);
        total++; if (enable !== 1'b0 || pronto !== 1'b1) begin bad++; $display("FAIL addi_after enable=%b pronto=%b want 0 1", enable, pronto); end
        total++; if (mem[1] !== 16'h0005 || wr_count !== w0 + 1) begin bad++; $display("FAIL addi_bank r1=%h writes=%0d want 0005 %0d", mem[1], wr_count - w0, 1); end
    endtask

    task automatic test_arith();
        run_op(3'b011, 4'd1, 4'd0, 4'd0, 7'd1, 1'b1);
        total++; if (mem[1] !== 16'hFFFF || estouro !== 1'b1) begin bad++; $display("FAIL subi_borrow got=%h/%b want FFFF/1", mem[1], estouro); end
        run_op(3'b110, 4'd2, 4'd0, 4'd0, 7'd2, 1'b1);
        total++; if (mem[2] !== 16'h0002 || estouro !== 1'b0) begin bad++; $display("FAIL load got=%h/%b want 0002/0", mem[2], estouro); end
        run_op(3'b000, 4'd3, 4'd1, 4'd2, 7'd0, 1'b1);
        total++; if (last_wr_addr !== 4'd3 || last_wr_data !== 16'h0001 || estouro !== 1'b1) begin
            bad++; $display("FAIL add_carry addr=%h data=%h est=%b want 3 0001 1", last_wr_addr, last_wr_data, estouro); end
        run_op(3'b010, 4'd4, 4'd2, 4'd1, 7'd0, 1'b1);
        total++; if (last_wr_addr !== 4'd4 || last_wr_data !== 16'h0003 || estouro !== 1'b1) begin
            bad++; $display("FAIL sub_borrow addr=%h data=%h est=%b want 4 0003 1", last_wr_addr, last_wr_data, estouro); end
        run_op(3'b010, 4'd6, 4'd1, 4'd2, 7'd0, 1'b1);
        total++; if (last_wr_data !== 16'hFFFD || estouro !== 1'b0 || resultado !== 16'hFFFD) begin
            bad++; $display("FAIL sub_noborrow data=%h est=%b res=%h want FFFD 0 FFFD", last_wr_data, estouro, resultado); end
    endtask

    task automatic test_same_reg();
        run_op(3'b110, 4'd5, 4'd0, 4'd0, 7'd7, 1'b1);
        run_op(3'b000, 4'd5, 4'd5, 4'd5, 7'd0, 1'b1);
        total++; if (mem[5] !== 16'd14 || estouro !== 1'b0) begin bad++; $display("FAIL same_reg r5=%h est=%b want 000e 0", mem[5], estouro); end
    endtask

    task automatic test_clear();
        int c0, nz;
        c0 = clr_count;
        run_op(3'b101, 4'd0, 4'd0, 4'd0, 7'd0, 1'b0);
        total++; if (ativar_clear !== 1'b1 || concluido !== 1'b1 || enable !== 1'b0 || pronto !== 1'b0) begin
            bad++; $display("FAIL clear_pulse clr=%b conc=%b en=%b pronto=%b want 1 1 0 0", ativar_clear, concluido, enable, pronto); end
        total++; if (resultado !== 16'd14) begin bad++; $display("FAIL clear_keeps_result got=%h want 000e", resultado); end
        @(negedge clk);
        total++; if (ativar_clear !== 1'b0 || pronto !== 1'b1) begin bad++; $display("FAIL clear_end clr=%b pronto=%b want 0 1", ativar_clear, pronto); end
        nz = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== 16'h0) nz++;
        total++; if (nz !== 0 || clr_count !== c0 + 1) begin bad++; $display("FAIL clear_bank nonzero=%0d pulses=%0d want 0 1", nz, clr_count - c0); end
        run_op(3'b000, 4'd6, 4'd1, 4'd5, 7'd0, 1'b1);
        total++; if (last_wr_data !== 16'h0 || last_wr_addr !== 4'd6) begin bad++; $display("FAIL clear_reads data=%h addr=%h want 0000 6", last_wr_data, last_wr_addr); end
    endtask

    task automatic test_back_to_back();
        int h0, w0;
        h0 = hs_count; w0 = wr_count;
        @(negedge clk);
        opcode = 3'b001; dest = 4'd7; src1 = 4'd7; src2 = 4'd3; imediato = 7'd3;
        instr_valida = 1'b1;
        repeat (12) @(negedge clk);
        instr_valida = 1'b0;
        total++; if (hs_count - h0 !== 3) begin bad++; $display("FAIL b2b_handshakes got=%0d want=3", hs_count - h0); end
        total++; if (wr_count - w0 !== 3 || mem[7] !== 16'd9) begin bad++; $display("FAIL b2b_result writes=%0d r7=%h want 3 0009", wr_count - w0, mem[7]); end
    endtask

    task automatic test_illegal();
        int w0;
        logic [15:0] r0;
        w0 = wr_count; r0 = resultado;
        run_op(3'b111, 4'd9, 4'd1, 4'd2, 7'd0, 1'b0);
        total++; if (erro !== 1'b1 || pronto !== 1'b1 || enable !== 1'b0 || concluido !== 1'b0) begin
            bad++; $display("FAIL illegal_pulse erro=%b pronto=%b en=%b conc=%b want 1 1 0 0", erro, pronto, enable, concluido); end
        @(negedge clk);
        total++; if (erro !== 1'b0) begin bad++; $display("FAIL illegal_pulse_end erro=%b want 0", erro); end
        repeat (3) @(negedge clk);
        total++; if (wr_count !== w0 || resultado !== r0) begin bad++; $display("FAIL illegal_nowrite writes=%0d res=%h want 0 %h", wr_count - w0, resultado, r0); end
        run_op(3'b110, 4'd8, 4'd0, 4'd0, 7'd64, 1'b1);
        run_op(3'b000, 4'd8, 4'd8, 4'd8, 7'd0, 1'b1);
        run_op(3'b000, 4'd8, 4'd8, 4'd8, 7'd0, 1'b1);
        total++; if (mem[8] !== 16'h0100) begin bad++; $display("FAIL mul_setup r8=%h want 0100", mem[8]); end
        w0 = wr_count;
`ifdef CONTROLADOR_MUL_EN
        run_op(3'b100, 4'd9, 4'd8, 4'd8, 7'd0, 1'b1);
        total++; if (last_wr_addr !== 4'd9 || last_wr_data !== 16'h0000 || estouro !== 1'b1 || wr_count !== w0 + 1) begin
            bad++; $display("FAIL mul_overflow addr=%h data=%h est=%b writes=%0d want 9 0000 1 1", last_wr_addr, last_wr_data, estouro, wr_count - w0); end
`else
        run_op(3'b100, 4'd9, 4'd8, 4'd8, 7'd0, 1'b0);
        total++; if (erro !== 1'b1 || pronto !== 1'b1) begin bad++; $display("FAIL mul_illegal erro=%b pronto=%b want 1 1", erro, pronto); end
        repeat (4) @(negedge clk);
        total++; if (wr_count !== w0) begin bad++; $display("FAIL mul_nowrite writes=%0d want 0", wr_count - w0); end
`endif
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = wr_count;
        run_op(3'b001, 4'd10, 4'd0, 4'd0, 7'd9, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (enable !== 1'b0 || concluido !== 1'b0 || ativar_clear !== 1'b1) begin
            bad++; $display("FAIL midrst_outputs en=%b conc=%b clr=%b want 0 0 1", enable, concluido, ativar_clear); end
        total++; if (pronto !== 1'b1 || resultado !== 16'h0 || estouro !== 1'b0) begin
            bad++; $display("FAIL midrst_state pronto=%b res=%h est=%b want 1 0000 0", pronto, resultado, estouro); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (pronto !== 1'b1 || ativar_clear !== 1'b0) begin bad++; $display("FAIL midrst_release pronto=%b clr=%b want 1 0", pronto, ativar_clear); end
        total++; if (wr_count !== w0 || mem[10] !== 16'h0) begin bad++; $display("FAIL midrst_nowrite writes=%0d r10=%h want 0 0000", wr_count - w0, mem[10]); end
        run_op(3'b001, 4'd10, 4'd0, 4'd0, 7'd9, 1'b1);
        total++; if (mem[10] !== 16'h0009) begin bad++; $display("FAIL midrst_recover r10=%h want 0009", mem[10]); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_arith();
        test_same_reg();
        test_clear();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
